color_fsm_timed: RTL

- Parametrised successor of the two-colour Moore FSM: four states (IDLE, RED, BLUE, HOLD), a command input, an auto-advance dwell timeout, a pause/resume with saved return state, and saturating per-colour occupancy counters.
- Sits between a command source and a downstream consumer of the per-state output code.
- Output codes and counter widths are parameters.

---
 rtl/color_fsm_pkg.sv | 23 ++
 rtl/sat_counter.sv | 24 ++
 rtl/color_fsm_timed.sv | 137 +++++++++++++
 3 files changed

// File: rtl/color_fsm_pkg.sv
// Shared types for the timed colour FSM: state and command encodings.
package color_fsm_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRed  = 2'd1,
    StBlue = 2'd2,
    StHold = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CmdNop   = 2'd0,
    CmdGo    = 2'd1,
    CmdPause = 2'd2,
    CmdStop  = 2'd3
  } cmd_e;

  // True for the two timed colour states.
  function automatic logic is_colour(state_e s);
    return (s == StRed) || (s == StBlue);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-high clear.
module sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q;

  // Count up on inc, stick at all-ones.
  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/color_fsm_timed.sv
// Four-state colour FSM with dwell timeout, pause/resume and per-colour occupancy counters.
module color_fsm_timed
  import color_fsm_pkg::*;
#(
  parameter int unsigned OUT_WIDTH = 2,
  parameter int unsigned CNT_WIDTH = 8,
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned IDLE_CODE = 0,
  parameter int unsigned RED_CODE  = 2,
  parameter int unsigned BLUE_CODE = 1,
  parameter int unsigned HOLD_CODE = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [1:0]           cmd,
  output logic [OUT_WIDTH-1:0] out,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] dwell,
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] red_cycles,
  output logic [CNT_WIDTH-1:0] blue_cycles
);

  localparam logic [CNT_WIDTH-1:0] DwellLast = CNT_WIDTH'(TIMEOUT - 1);

  state_e                 state_q, state_d;
  state_e                 saved_q, saved_d;
  logic [CNT_WIDTH-1:0]   dwell_q, dwell_d;
  cmd_e                   cmd_w;

  assign cmd_w = cmd_e'(cmd);

  // Auto-advance fires only on an enabled NOP cycle at the last dwell count.
  assign timeout = en && is_colour(state_q) && (cmd_w == CmdNop) && (dwell_q == DwellLast);

  // Next state, saved return state and dwell.
  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    dwell_d = dwell_q;
    if (en) begin
      unique case (state_q)
        StIdle: begin
          if (cmd_w == CmdGo) state_d = StRed;
        end
        StRed: begin
          if (cmd_w == CmdStop) begin
            state_d = StIdle;
          end else if (cmd_w == CmdGo) begin
            state_d = StBlue;
          end else if (cmd_w == CmdPause) begin
            state_d = StHold;
            saved_d = StRed;
          end else if (timeout) begin
            state_d = StBlue;
          end
        end
        StBlue: begin
          if (cmd_w == CmdStop) begin
            state_d = StIdle;
          end else if (cmd_w == CmdGo) begin
            state_d = StRed;
          end else if (cmd_w == CmdPause) begin
            state_d = StHold;
            saved_d = StBlue;
          end else if (timeout) begin
            state_d = StRed;
          end
        end
        StHold: begin
          if (cmd_w == CmdStop) begin
            state_d = StIdle;
          end else if (cmd_w == CmdGo) begin
            state_d = saved_q;
          end
        end
      endcase

      // Any state change restarts the visit; only colour states accumulate dwell.
      if (state_d != state_q) begin
        dwell_d = '0;
      end else if (is_colour(state_q)) begin
        dwell_d = dwell_q + 1'b1;
      end else begin
        dwell_d = '0;
      end
    end
  end

  // State, saved return state and dwell registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      saved_q <= StRed;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      dwell_q <= dwell_d;
    end
  end

  // Moore output decode.
  always_comb begin
    out = '0;
    unique case (state_q)
      StIdle: out = OUT_WIDTH'(IDLE_CODE);
      StRed:  out = OUT_WIDTH'(RED_CODE);
      StBlue: out = OUT_WIDTH'(BLUE_CODE);
      StHold: out = OUT_WIDTH'(HOLD_CODE);
    endcase
  end

  assign state = state_q;
  assign dwell = dwell_q;

  // Occupancy counts run on every clock regardless of en.
  sat_counter #(
    .Width (CNT_WIDTH)
  ) u_red_cnt (
    .clk_i   (clk),
    .clr_i   (rst),
    .inc_i   (state_q == StRed),
    .count_o (red_cycles)
  );

  sat_counter #(
    .Width (CNT_WIDTH)
  ) u_blue_cnt (
    .clk_i   (clk),
    .clr_i   (rst),
    .inc_i   (state_q == StBlue),
    .count_o (blue_cycles)
  );

endmodule
